// File: rtl/ifetch_pkg.sv
// Shared fetch-side types and constants: address/word types, boolean
// constants, RISC-V opcode field, and the instruction-queue payload.
package ifetch_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned OPC_LO   = 0;
   localparam int unsigned OPC_HI   = 6;
   localparam int unsigned OPC_W    = OPC_HI - OPC_LO + 1;
   localparam int unsigned INST_B   = 4;

   typedef logic [XLEN-1:0] addr_t;
   typedef logic [XLEN-1:0] word_t;

   localparam logic  TRUE      = 1'b1;
   localparam logic  FALSE     = 1'b0;
   localparam word_t ZERO_WORD = '0;

   // Fetch PCs are word aligned; this mask clears the byte offset.
   localparam addr_t PC_MASK   = ~addr_t'(INST_B - 1);

   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam word_t            NOP_INST   = 32'h0000_0013;

   // One instruction-queue entry as presented to decode.
   typedef struct packed {
      addr_t pc;
      word_t inst;
      logic  pred_taken;
      addr_t pred_pc;
   } iq_entry_t;

endpackage

// File: rtl/ifetch.sv
// ifetch: instruction-fetch sequencer. Owns the fetch PC, issues one icache
// request at a time, presents each returned instruction to the branch
// predictor, and pushes {pc, inst, pred_taken, pred_pc} into the
// instruction queue. A commit-side redirect overrides all other activity.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ena                      global enable; low freezes all state
//   ic_req/ic_addr           fetch request pulse and held fetch address
//   ic_valid/ic_inst         icache response strobe and instruction word
//   pd_ena/pd_pc/pd_inst     predictor enable and instruction under prediction
//   pd_taken/pd_off          combinational prediction and target offset
//   iq_full                  queue cannot accept a push this cycle
//   iq_push/iq_*             push strobe and pushed entry
//   rd_ena/rd_pc             redirect request and target
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   output logic            ic_req,
   output logic [XLEN-1:0] ic_addr,
   input  logic            ic_valid,
   input  logic [XLEN-1:0] ic_inst,
   output logic            pd_ena,
   output logic [XLEN-1:0] pd_pc,
   output logic [XLEN-1:0] pd_inst,
   input  logic            pd_taken,
   input  logic [XLEN-1:0] pd_off,
   input  logic            iq_full,
   output logic            iq_push,
   output logic [XLEN-1:0] iq_pc,
   output logic [XLEN-1:0] iq_inst,
   output logic            iq_pred_taken,
   output logic [XLEN-1:0] iq_pred_pc,
   input  logic            rd_ena,
   input  logic [XLEN-1:0] rd_pc
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0] state_q, state_d;
   addr_t      pc_q, pc_d;
   word_t      inst_buf_q, inst_buf_d;
   addr_t      req_addr_q, req_addr_d;

   logic       req_c;
   logic       push_c;
   word_t      cur_inst_c;
   addr_t      next_pc_c;
   iq_entry_t  entry_c;

   // Instruction under prediction: bypassed response in WAIT, buffer in HOLD.
   always_comb begin
      cur_inst_c = ZERO_WORD;
      if (state_q == ST_WAIT) begin
         cur_inst_c = ic_inst;
      end else if (state_q == ST_HOLD) begin
         cur_inst_c = inst_buf_q;
      end
   end

   // Predicted successor; modulo 2^32, kept word aligned.
   always_comb begin
      next_pc_c = pd_taken ? (pc_q + pd_off) : (pc_q + addr_t'(INST_B));
      next_pc_c = next_pc_c & PC_MASK;
   end

   // Next-state and strobe logic.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_buf_d = inst_buf_q;
      req_addr_d = req_addr_q;
      req_c      = FALSE;
      push_c     = FALSE;

      if (!rst && ena) begin
         if (rd_ena) begin
            pc_d       = rd_pc & PC_MASK;
            inst_buf_d = ZERO_WORD;
            case (state_q)
               // An outstanding request must be drained unless it lands now.
               ST_WAIT:  state_d = ic_valid ? ST_FETCH : ST_DRAIN;
               // A response landing together with a repeat redirect is the
               // orphan itself, so draining is complete.
               ST_DRAIN: state_d = ic_valid ? ST_FETCH : ST_DRAIN;
               default:  state_d = ST_FETCH;
            endcase
         end else begin
            case (state_q)
               ST_FETCH: begin
                  if (!iq_full) begin
                     req_c      = TRUE;
                     req_addr_d = pc_q;
                     state_d    = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (ic_valid) begin
                     if (!iq_full) begin
                        push_c  = TRUE;
                        pc_d    = next_pc_c;
                        state_d = ST_FETCH;
                     end else begin
                        inst_buf_d = ic_inst;
                        state_d    = ST_HOLD;
                     end
                  end
               end
               ST_HOLD: begin
                  if (!iq_full) begin
                     push_c  = TRUE;
                     pc_d    = next_pc_c;
                     state_d = ST_FETCH;
                  end
               end
               default: begin
                  if (ic_valid) begin
                     state_d = ST_FETCH;
                  end
               end
            endcase
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC & PC_MASK;
         inst_buf_q <= ZERO_WORD;
         req_addr_q <= RESET_PC & PC_MASK;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_buf_q <= inst_buf_d;
         req_addr_q <= req_addr_d;
      end
   end

   always_comb begin
      entry_c.pc         = pc_q;
      entry_c.inst       = cur_inst_c;
      entry_c.pred_taken = pd_taken;
      entry_c.pred_pc    = next_pc_c;
   end

   // ic_addr tracks pc while idle, then holds the issued address even if a
   // redirect moves pc before the response returns.
   assign ic_req        = req_c;
   assign ic_addr       = rst ? ZERO_WORD :
                          ((state_q == ST_FETCH) ? pc_q : req_addr_q);
   assign pd_ena        = ena;
   assign pd_pc         = rst ? ZERO_WORD : pc_q;
   assign pd_inst       = rst ? ZERO_WORD : cur_inst_c;

   // Queue payload is zero whenever no push is in progress.
   assign iq_push       = push_c;
   assign iq_pc         = push_c ? entry_c.pc         : ZERO_WORD;
   assign iq_inst       = push_c ? entry_c.inst       : ZERO_WORD;
   assign iq_pred_taken = push_c ? entry_c.pred_taken : FALSE;
   assign iq_pred_pc    = push_c ? entry_c.pred_pc    : ZERO_WORD;

endmodule
